// File: rtl/sd_sector_dma_pkg.sv
// rtl/sd_sector_dma_pkg.sv - shared states, error codes and sizing for the SD sector DMA
package sd_sector_dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_ISSUE,
    S_RECV,
    S_DRAIN,
    S_DONE,
    S_ERROR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_RDY_TO  = 2'd1,
    ERR_DATA_TO = 2'd2,
    ERR_OVF     = 2'd3
  } err_t;

  localparam int DEFAULT_SECTOR_BYTES = 512;
  localparam int BCNT_W               = 10;
  localparam int TMO_W                = 25;

  function automatic logic is_busy(input state_t s);
    return !((s == S_IDLE) || (s == S_DONE) || (s == S_ERROR));
  endfunction

endpackage

// File: rtl/sd_sector_dma_word_fifo.sv
// rtl/sd_sector_dma_word_fifo.sv - word FIFO between the byte packer and the RAM write port
module sd_word_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [PW:0]   r_cnt;
  logic          w_pop;
  logic          w_push;

  assign empty  = (r_cnt == '0);
  assign full   = (r_cnt == FULL_CNT);
  assign dout   = r_mem[r_rd];
  assign w_pop  = pop & ~empty;
  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign w_push = push & (~full | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr] <= din;
  end

endmodule

// File: rtl/sd_sector_dma.sv
// rtl/sd_sector_dma.sv - sequences sd_controller for one sector read and writes it into RAM
module sd_sector_dma
  import sd_sector_dma_pkg::*;
#(
  parameter int ADDR_W       = 12,
  parameter int SECTOR_BYTES = DEFAULT_SECTOR_BYTES,
  parameter int FIFO_DEPTH   = 4,
  parameter int TIMEOUT_CYC  = 25_000_000
) (
  input  logic              CLOCK_50,
  input  logic              KEY0,
  input  logic              start,
  input  logic [31:0]       sector,
  input  logic [ADDR_W-1:0] dst_waddr,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_code,
  output logic              sd_rd,
  output logic [31:0]       sd_address,
  input  logic              sd_ready,
  input  logic              sd_byte_available,
  input  logic [7:0]        sd_dout,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt
);

  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(SECTOR_BYTES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

  state_t             r_state;
  err_t               r_err;
  logic               r_done;
  logic               r_sd_rd;
  logic [31:0]        r_sector;
  logic [ADDR_W-1:0]  r_dst;
  logic [ADDR_W-1:0]  r_wcnt;
  logic               r_avail_d;
  logic               r_edge;
  logic [7:0]         r_byte;
  logic [23:0]        r_pack;
  logic [BCNT_W-1:0]  r_bcnt;
  logic [TMO_W-1:0]   r_timer;

  logic               w_xfer;
  logic               w_pop;
  logic               w_word_done;
  logic               w_ovf;
  logic               w_fifo_push;
  logic [31:0]        w_push_word;
  logic [31:0]        w_head;
  logic               w_full;
  logic               w_empty;
  logic               w_flush;
  logic               w_tmo;

  assign busy       = is_busy(r_state);
  assign done       = r_done;
  assign err_code   = r_err;
  assign sd_rd      = r_sd_rd;
  assign sd_address = r_sector;

  // Write side only runs while the sector is in flight; in ERROR the FIFO is being flushed.
  assign w_xfer      = (r_state == S_RECV) || (r_state == S_DRAIN);
  assign mem_req     = w_xfer & ~w_empty;
  assign mem_waddr   = r_dst + r_wcnt;
  assign mem_wdata   = w_head;
  assign w_pop       = mem_req & mem_gnt;
  assign w_word_done = (r_state == S_RECV) & r_edge & (r_bcnt[1:0] == 2'd3);
  assign w_ovf       = w_word_done & w_full & ~w_pop;
  assign w_fifo_push = w_word_done & ~w_ovf;
  assign w_push_word = {r_byte, r_pack};
  assign w_flush     = (r_state == S_ERROR);
  assign w_tmo       = (r_timer == TMO_LAST);

  sd_word_fifo #(
    .W     (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLOCK_50),
    .rst_n (KEY0),
    .flush (w_flush),
    .push  (w_fifo_push),
    .pop   (w_pop),
    .din   (w_push_word),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      r_state   <= S_IDLE;
      r_err     <= ERR_NONE;
      r_done    <= 1'b0;
      r_sd_rd   <= 1'b0;
      r_sector  <= '0;
      r_dst     <= '0;
      r_wcnt    <= '0;
      r_avail_d <= 1'b0;
      r_edge    <= 1'b0;
      r_byte    <= '0;
      r_pack    <= '0;
      r_bcnt    <= '0;
      r_timer   <= '0;
    end else begin
      // Byte strobe is a level; one byte per rising edge, consumed a cycle later.
      r_avail_d <= sd_byte_available;
      r_edge    <= sd_byte_available & ~r_avail_d;
      r_byte    <= sd_dout;
      if (w_pop) r_wcnt <= r_wcnt + 1'b1;

      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            r_state  <= S_WAIT_RDY;
            r_sector <= sector;
            r_dst    <= dst_waddr;
            r_done   <= 1'b0;
            r_err    <= ERR_NONE;
            r_wcnt   <= '0;
            r_bcnt   <= '0;
            r_timer  <= '0;
          end
        end
        S_WAIT_RDY: begin
          if (sd_ready) begin
            r_state <= S_ISSUE;
            r_sd_rd <= 1'b1;
            r_timer <= '0;
          end else if (w_tmo) begin
            r_state <= S_ERROR;
            r_err   <= ERR_RDY_TO;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_ISSUE: begin
          if (!sd_ready) begin
            r_state <= S_RECV;
            r_sd_rd <= 1'b0;
            r_timer <= '0;
          end else if (w_tmo) begin
            r_state <= S_ERROR;
            r_sd_rd <= 1'b0;
            r_err   <= ERR_RDY_TO;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_RECV: begin
          if (w_ovf) begin
            r_state <= S_ERROR;
            r_err   <= ERR_OVF;
          end else if (r_edge) begin
            case (r_bcnt[1:0])
              2'd0:    r_pack[7:0]   <= r_byte;
              2'd1:    r_pack[15:8]  <= r_byte;
              2'd2:    r_pack[23:16] <= r_byte;
              default: r_pack        <= r_pack;
            endcase
            r_bcnt  <= r_bcnt + 1'b1;
            r_timer <= '0;
            if (r_bcnt == LAST_BYTE) r_state <= S_DRAIN;
          end else if (w_tmo) begin
            r_state <= S_ERROR;
            r_err   <= ERR_DATA_TO;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_DRAIN: begin
          if (w_empty) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
